// File: rtl/line_spike_unpacker_if.sv
// Bundles the line-store read port and the per-pixel spike stream of line_spike_unpacker.
// master: unpacker side (drives read strobe/address and the spike stream).
// slave : environment side (returns line data, supplies consumer ready).
interface line_spike_unpacker_if #(
    parameter int TIME_STEPS = 4,
    parameter int IMG_WIDTH  = 32,
    parameter int ADDR_W     = 10
);
    // Line-store read port
    logic                            o_rd_en;
    logic [ADDR_W-1:0]               o_rd_addr;
    logic [IMG_WIDTH*TIME_STEPS-1:0] i_rd_data;

    // Spike stream
    logic [TIME_STEPS-1:0]           o_spikes;
    logic                            o_spikes_valid;
    logic                            i_spikes_ready;
    logic                            o_line_last;

    modport master (
        output o_rd_en, o_rd_addr, o_spikes, o_spikes_valid, o_line_last,
        input  i_rd_data, i_spikes_ready
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_spikes, o_spikes_valid, o_line_last,
        output i_rd_data, i_spikes_ready
    );
endinterface

// File: rtl/line_spike_unpacker.sv
// Replays packed spike lines from the line store as a per-pixel spike stream, prefetching one line ahead.
// Latency: start -> read at +1 -> line data at +1+RD_LAT -> first pixel valid at +2+RD_LAT; 1 pixel/cycle after.
// Backpressure: valid/data held while ready is low; reads stop once the prefetch slot is full.
//
// Ports:
//   s_clk, s_rst_n  clock, async active-low reset
//   i_start         frame start pulse (accepted only in IDLE)
//   o_busy          high while the frame is running
//   o_done          1-cycle pulse after the last pixel of the frame is accepted
//   bus (master)    o_rd_en/o_rd_addr/i_rd_data line-store port;
//                   o_spikes/o_spikes_valid/i_spikes_ready/o_line_last spike stream
module line_spike_unpacker #(
    parameter int TIME_STEPS = 4,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    line_spike_unpacker_if.master bus
);
    localparam int LINE_W = IMG_WIDTH * TIME_STEPS;
    localparam int PIX_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LINES     = ADDR_W'(IMG_HEIGHT);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t state_q, state_d;

    // Emit shift register: current line, pixel 0 in the LSBs
    logic [LINE_W-1:0] e_q, e_d;
    logic              e_full_q, e_full_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    // Prefetch slot
    logic [LINE_W-1:0] p_q, p_d;
    logic              p_full_q, p_full_d;
    // One bit per cycle of read latency; MSB marks data arriving this cycle
    logic [RD_LAT-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] req_q, req_d;
    // Index of the line currently held in E
    logic [ADDR_W-1:0] line_q, line_d;

    logic rd_en, ret, hs, last_hs, final_hs, load_e;

    always_comb begin
        rd_en    = (state_q == ST_RUN) && !p_full_q && !(|pend_q) && (req_q < LINES);
        ret      = pend_q[RD_LAT-1];
        hs       = e_full_q && bus.i_spikes_ready;
        last_hs  = hs && (pix_q == PIX_LAST);
        final_hs = last_hs && (line_q == LINE_LAST);
        // Refill E when it empties (or is about to); returning data bypasses P
        load_e   = (p_full_q || ret) && (!e_full_q || last_hs);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_start)  state_d = ST_RUN;
            ST_RUN:  if (final_hs) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy             = (state_q == ST_RUN);
        o_done             = (state_q == ST_DONE);
        bus.o_rd_en        = rd_en;
        bus.o_rd_addr      = req_q;
        bus.o_spikes       = e_q[TIME_STEPS-1:0];
        bus.o_spikes_valid = e_full_q;
        bus.o_line_last    = e_full_q && (pix_q == PIX_LAST);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        e_d      = e_q;
        e_full_d = e_full_q;
        pix_d    = pix_q;
        p_d      = p_q;
        p_full_d = p_full_q;
        req_d    = req_q;
        line_d   = line_q;
        pend_d   = '0;

        pend_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            pend_d[i] = pend_q[i-1];
        end

        if (state_q == ST_IDLE && i_start) begin
            req_d  = '0;
            line_d = '0;
        end else begin
            if (rd_en)   req_d  = req_q + ADDR_W'(1);
            if (last_hs) line_d = line_q + ADDR_W'(1);
        end

        if (load_e) begin
            e_d      = p_full_q ? p_q : bus.i_rd_data;
            e_full_d = 1'b1;
            pix_d    = '0;
        end else if (hs) begin
            e_d = e_q >> TIME_STEPS;
            if (pix_q == PIX_LAST) begin
                pix_d    = '0;
                e_full_d = 1'b0;
            end else begin
                pix_d = pix_q + PIX_W'(1);
            end
        end

        if (load_e && p_full_q) p_full_d = 1'b0;
        // Returning data parks in P unless it went straight into E
        if (ret && !(load_e && !p_full_q)) begin
            p_d      = bus.i_rd_data;
            p_full_d = 1'b1;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            e_q      <= '0;
            e_full_q <= 1'b0;
            pix_q    <= '0;
            p_q      <= '0;
            p_full_q <= 1'b0;
            pend_q   <= '0;
            req_q    <= '0;
            line_q   <= '0;
        end else begin
            e_q      <= e_d;
            e_full_q <= e_full_d;
            pix_q    <= pix_d;
            p_q      <= p_d;
            p_full_q <= p_full_d;
            pend_q   <= pend_d;
            req_q    <= req_d;
            line_q   <= line_d;
        end
    end
endmodule

// File: tb/tb_line_spike_unpacker.sv
module tb_line_spike_unpacker;
    localparam int TS = 4;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;

    line_spike_unpacker_if #(.TIME_STEPS(TS), .IMG_WIDTH(W), .ADDR_W(AW)) ifa ();
    line_spike_unpacker_if #(.TIME_STEPS(TS), .IMG_WIDTH(W), .ADDR_W(AW)) ifb ();

    line_spike_unpacker #(.TIME_STEPS(TS), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .RD_LAT(1)) dut_a (
        .s_clk(clk), .s_rst_n(rst_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a), .bus(ifa.master)
    );
    line_spike_unpacker #(.TIME_STEPS(TS), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .RD_LAT(3)) dut_b (
        .s_clk(clk), .s_rst_n(rst_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b), .bus(ifb.master)
    );

    // Line store models: 1-cycle and 3-cycle read latency
    logic [15:0] mem [2];
    logic [15:0] pb1, pb2;
    always @(posedge clk) if (ifa.o_rd_en) ifa.i_rd_data <= mem[ifa.o_rd_addr[0]];
    always @(posedge clk) begin
        pb1           <= mem[ifb.o_rd_addr[0]];
        pb2           <= pb1;
        ifb.i_rd_data <= pb2;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {line_last, spikes} for line0=DCBA, line1=3210
    int exp_tab [8] = '{'h0A, 'h0B, 'h0C, 'h1D, 'h00, 'h01, 'h02, 'h13};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- Scoreboard / monitor for DUT A ----------------
    int exp_qa[$];
    int rd_addr_a[$];
    int hs_a, first_a, last_a, done_rel_a, done_cnt_a, rd_cnt_a, start_cyc_a, prev_a;
    bit done_seen_a, hold_a;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_a = 1'b0;
        end else begin
            if (ifa.o_rd_en) begin
                rd_addr_a.push_back(int'(ifa.o_rd_addr));
                rd_cnt_a++;
            end
            if (hold_a) begin
                chk("a_hold_valid", int'(ifa.o_spikes_valid), 1);
                chk("a_hold_spikes", int'(ifa.o_spikes), prev_a);
            end
            if (ifa.o_spikes_valid && ifa.i_spikes_ready) begin
                hs_a++;
                if (hs_a == 1) first_a = cyc - start_cyc_a;
                last_a = cyc - start_cyc_a;
                if (exp_qa.size() == 0) chk("a_unexpected_pixel", hs_a, 0);
                else chk("a_pixel", int'({ifa.o_line_last, ifa.o_spikes}), exp_qa.pop_front());
            end
            hold_a = ifa.o_spikes_valid && !ifa.i_spikes_ready;
            prev_a = int'(ifa.o_spikes);
            if (done_a) begin
                done_cnt_a++;
                done_rel_a  = cyc - start_cyc_a;
                done_seen_a = 1'b1;
            end
        end
    end

    // ---------------- Scoreboard / monitor for DUT B ----------------
    int exp_qb[$];
    int hs_b, first_b, last_b, done_rel_b, done_cnt_b, rd_cnt_b, start_cyc_b;
    bit done_seen_b;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifb.o_rd_en) rd_cnt_b++;
            if (ifb.o_spikes_valid && ifb.i_spikes_ready) begin
                hs_b++;
                if (hs_b == 1) first_b = cyc - start_cyc_b;
                last_b = cyc - start_cyc_b;
                if (exp_qb.size() == 0) chk("b_unexpected_pixel", hs_b, 0);
                else chk("b_pixel", int'({ifb.o_line_last, ifb.o_spikes}), exp_qb.pop_front());
            end
            if (done_b) begin
                done_cnt_b++;
                done_rel_b  = cyc - start_cyc_b;
                done_seen_b = 1'b1;
            end
        end
    end

    // mode 0: ready=1; 1: ready toggles; 2: ready=0 for 20 cycles then 1
    // mid: cycle to re-pulse start (0=never); sid: pulse start in DONE; rst_at: reset after N handshakes
    task automatic run_a(input int mode, input int mid, input bit sid, input int rst_at);
        bit aborted = 1'b0;
        hs_a = 0; rd_cnt_a = 0; done_cnt_a = 0; done_seen_a = 1'b0;
        first_a = -1; last_a = -1; done_rel_a = -1;
        rd_addr_a.delete();
        for (int i = 0; i < 8; i++) exp_qa.push_back(exp_tab[i]);
        @(posedge clk); #1;
        chk("a_idle_busy", int'(busy_a), 0);
        start_a = 1'b1;
        start_cyc_a = cyc;
        ifa.i_spikes_ready = (mode == 0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start_a = (k == mid) || (sid && done_a);
            ifa.i_spikes_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 1) : (k > 20);
            if (mode == 0 && k == 1) chk("a_busy_run", int'(busy_a), 1);
            if (mode == 2 && k == 20) begin
                chk("a_stall_valid", int'(ifa.o_spikes_valid), 1);
                chk("a_stall_spikes", int'(ifa.o_spikes), 'hA);
                chk("a_stall_reads", rd_cnt_a, 2);
            end
            if (rst_at > 0 && hs_a == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", int'(ifa.o_spikes_valid), 0);
                chk("rst_spikes", int'(ifa.o_spikes), 0);
                chk("rst_last", int'(ifa.o_line_last), 0);
                chk("rst_busy", int'(busy_a), 0);
                chk("rst_done", int'(done_a), 0);
                chk("rst_rd_en", int'(ifa.o_rd_en), 0);
                start_a = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (done_seen_a && !start_a) break;
            if (k == 300) chk("a_frame_timeout", int'(done_seen_a), 1);
        end
        if (aborted) begin
            exp_qa.delete();
            return;
        end
        chk("a_handshakes", hs_a, W * H);
        chk("a_queue_left", exp_qa.size(), 0);
        chk("a_reads", rd_cnt_a, 2);
        if (rd_addr_a.size() >= 2) begin
            chk("a_addr0", rd_addr_a[0], 0);
            chk("a_addr1", rd_addr_a[1], 1);
        end
        chk("a_done_pulses", done_cnt_a, 1);
        if (mode == 0) begin
            chk("a_first_valid_cycle", first_a, 3);
            chk("a_last_pixel_cycle", last_a, 10);
            chk("a_done_cycle", done_rel_a, 11);
        end
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_after_busy", int'(busy_a), 0);
        chk("a_after_valid", int'(ifa.o_spikes_valid), 0);
        chk("a_after_reads", rd_cnt_a, 2);
        chk("a_after_done_pulses", done_cnt_a, 1);
    endtask

    task automatic run_b();
        hs_b = 0; rd_cnt_b = 0; done_cnt_b = 0; done_seen_b = 1'b0;
        first_b = -1; last_b = -1; done_rel_b = -1;
        for (int i = 0; i < 8; i++) exp_qb.push_back(exp_tab[i]);
        @(posedge clk); #1;
        start_b = 1'b1;
        start_cyc_b = cyc;
        ifb.i_spikes_ready = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (done_seen_b) break;
            if (k == 300) chk("b_frame_timeout", int'(done_seen_b), 1);
        end
        chk("b_handshakes", hs_b, W * H);
        chk("b_queue_left", exp_qb.size(), 0);
        chk("b_reads", rd_cnt_b, 2);
        chk("b_first_valid_cycle", first_b, 5);
        chk("b_last_pixel_cycle", last_b, 12);
        chk("b_done_cycle", done_rel_b, 13);
        chk("b_done_pulses", done_cnt_b, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.i_spikes_ready = 1'b0;
        ifb.i_spikes_ready = 1'b0;
        mem[0] = 16'hDCBA;
        mem[1] = 16'h3210;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_valid", int'(ifa.o_spikes_valid), 0);
        chk("reset_a_busy", int'(busy_a), 0);
        chk("reset_a_done", int'(done_a), 0);
        chk("reset_a_rd_en", int'(ifa.o_rd_en), 0);
        chk("reset_b_valid", int'(ifb.o_spikes_valid), 0);
        rst_n = 1'b1;

        run_a(0, 0, 1'b0, 0);     // full-rate frame
        run_a(1, 0, 1'b0, 0);     // toggling ready
        run_a(2, 0, 1'b0, 0);     // long stall then drain
        run_a(0, 5, 1'b1, 0);     // restarts mid-frame and in DONE ignored
        run_a(0, 0, 1'b0, 0);     // replay after IDLE

        run_a(0, 0, 1'b0, 3);     // reset after third pixel
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt_a, 0);
        chk("rst_idle_valid", int'(ifa.o_spikes_valid), 0);
        run_a(0, 0, 1'b0, 0);     // clean frame after abort

        run_b();                  // 3-cycle read latency

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
